// File: rtl/iir_biquad_seq_if.sv
// rtl/iir_biquad_seq_if.sv - sample handshake and mux bus of the biquad sequencer
interface iir_biquad_seq_if #(
  parameter int N = 20
);
  logic         start;
  logic [N-1:0] Uk_in;
  logic [N-1:0] muxS;
  logic [N-1:0] muxC;
  logic [N-1:0] muxZ;
  logic [2:0]   controlS;
  logic [1:0]   controlC;
  logic [2:0]   controlZ;
  logic [N-1:0] Uk;
  logic [N-1:0] fk;
  logic [N-1:0] fk1;
  logic [N-1:0] fk2;
  logic [N-1:0] yk;
  logic [N-1:0] acum1;
  logic [N-1:0] acum2;
  logic [N-1:0] acum3;
  logic         busy;
  logic         done;

  // Host and operand mux side
  modport master (
    output start, Uk_in, muxS, muxC, muxZ,
    input  controlS, controlC, controlZ,
    input  Uk, fk, fk1, fk2, yk, acum1, acum2, acum3,
    input  busy, done
  );

  // Sequencer side
  modport slave (
    input  start, Uk_in, muxS, muxC, muxZ,
    output controlS, controlC, controlZ,
    output Uk, fk, fk1, fk2, yk, acum1, acum2, acum3,
    output busy, done
  );
endinterface

// File: rtl/iir_biquad_seq.sv
// rtl/iir_biquad_seq.sv - direct-form-II biquad sequencer, MAC and state registers
module iir_biquad_seq #(
  parameter int N = 20,
  parameter int F = 14
) (
  input logic             clk,
  input logic             reset_n,
  iir_biquad_seq_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_S1   = 3'd1,
    ST_S2   = 3'd2,
    ST_S3   = 3'd3,
    ST_S4   = 3'd4,
    ST_S5   = 3'd5,
    ST_UPD  = 3'd6
  } state_t;

  // Saturation rails expressed in the widened sum width
  localparam logic signed [2*N:0] C_SUM_MAX = {{(N+2){1'b0}}, {(N-1){1'b1}}};
  localparam logic signed [2*N:0] C_SUM_MIN = {{(N+2){1'b1}}, {(N-1){1'b0}}};

  state_t r_state;
  state_t w_next;

  logic [2:0] w_ctl_s;
  logic [1:0] w_ctl_c;
  logic [2:0] w_ctl_z;
  logic       w_busy;
  logic       w_done;

  logic [N-1:0] r_uk;
  logic [N-1:0] r_fk;
  logic [N-1:0] r_fk1;
  logic [N-1:0] r_fk2;
  logic [N-1:0] r_yk;
  logic [N-1:0] r_acum1;
  logic [N-1:0] r_acum2;
  logic [N-1:0] r_acum3;

  logic signed [2*N-1:0] w_s_ext;
  logic signed [2*N-1:0] w_c_ext;
  logic signed [2*N-1:0] w_prod;
  logic signed [2*N-1:0] w_shift;
  logic signed [2*N:0]   w_z_ext;
  logic signed [2*N:0]   w_sum;
  logic [N-1:0]          w_mac;

  // Operands are widened to the full product width so the low 2N bits are exact
  assign w_s_ext = {{N{bus.muxS[N-1]}}, bus.muxS};
  assign w_c_ext = {{N{bus.muxC[N-1]}}, bus.muxC};
  assign w_prod  = w_s_ext * w_c_ext;
  // Arithmetic shift floors toward -inf, matching the fixed-point convention
  assign w_shift = w_prod >>> F;
  assign w_z_ext = {{(N+1){bus.muxZ[N-1]}}, bus.muxZ};
  assign w_sum   = {w_shift[2*N-1], w_shift} + w_z_ext;

  // Clamp the accumulated sum to the N-bit signed range
  always_comb begin
    w_mac = w_sum[N-1:0];
    if (w_sum > C_SUM_MAX) begin
      w_mac = {1'b0, {(N-1){1'b1}}};
    end else if (w_sum < C_SUM_MIN) begin
      w_mac = {1'b1, {(N-1){1'b0}}};
    end
  end

  // Next state and mux controls decoded from the current step
  always_comb begin
    w_next  = ST_IDLE;
    w_ctl_s = 3'b000;
    w_ctl_c = 2'b00;
    w_ctl_z = 3'b000;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_next = bus.start ? ST_S1 : ST_IDLE;
      end
      ST_S1: begin
        w_ctl_s = 3'b001; w_ctl_c = 2'b01; w_ctl_z = 3'b001;
        w_busy  = 1'b1;
        w_next  = ST_S2;
      end
      ST_S2: begin
        w_ctl_s = 3'b010; w_ctl_c = 2'b10; w_ctl_z = 3'b011;
        w_busy  = 1'b1;
        w_next  = ST_S3;
      end
      ST_S3: begin
        w_ctl_s = 3'b011; w_ctl_c = 2'b11; w_ctl_z = 3'b000;
        w_busy  = 1'b1;
        w_next  = ST_S4;
      end
      ST_S4: begin
        w_ctl_s = 3'b100; w_ctl_c = 2'b01; w_ctl_z = 3'b100;
        w_busy  = 1'b1;
        w_next  = ST_S5;
      end
      ST_S5: begin
        w_ctl_s = 3'b101; w_ctl_c = 2'b10; w_ctl_z = 3'b101;
        w_busy  = 1'b1;
        w_next  = ST_UPD;
      end
      ST_UPD: begin
        w_busy = 1'b1;
        w_done = 1'b1;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Step register; a reset abandons any sample in flight
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Each step writes only its own destination register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_uk    <= '0;
      r_fk    <= '0;
      r_fk1   <= '0;
      r_fk2   <= '0;
      r_yk    <= '0;
      r_acum1 <= '0;
      r_acum2 <= '0;
      r_acum3 <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (bus.start) r_uk <= bus.Uk_in;
        ST_S1:   r_acum1 <= w_mac;
        ST_S2:   r_fk    <= w_mac;
        ST_S3:   r_acum2 <= w_mac;
        ST_S4:   r_acum3 <= w_mac;
        ST_S5:   r_yk    <= w_mac;
        ST_UPD: begin
          r_fk2 <= r_fk1;
          r_fk1 <= r_fk;
        end
        default: ;
      endcase
    end
  end

  assign bus.controlS = w_ctl_s;
  assign bus.controlC = w_ctl_c;
  assign bus.controlZ = w_ctl_z;
  assign bus.busy     = w_busy;
  assign bus.done     = w_done;
  assign bus.Uk       = r_uk;
  assign bus.fk       = r_fk;
  assign bus.fk1      = r_fk1;
  assign bus.fk2      = r_fk2;
  assign bus.yk       = r_yk;
  assign bus.acum1    = r_acum1;
  assign bus.acum2    = r_acum2;
  assign bus.acum3    = r_acum3;

endmodule

// File: tb/tb_iir_biquad_seq.sv
// tb/tb_iir_biquad_seq.sv - randomized bench for the biquad sequencer against a sample-level model
module tb_iir_biquad_seq;

  localparam int N = 20;
  localparam int F = 14;

  localparam longint A1 = 16957;
  localparam longint A2 = -8000;
  localparam longint B0 = 9841;
  localparam longint B1 = -19677;
  localparam longint B2 = 9841;
  localparam longint VMAX = 524287;
  localparam longint VMIN = -524288;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  longint m_uk, m_fk, m_fk1, m_fk2, m_yk, m_a1, m_a2, m_a3;

  iir_biquad_seq_if #(.N(N)) bus ();

  iir_biquad_seq #(.N(N), .F(F)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Coefficient / operand / addend mux
  always_comb begin
    case (bus.controlS)
      3'b001:  bus.muxS = N'(A1);
      3'b010:  bus.muxS = N'(A2);
      3'b011:  bus.muxS = N'(B0);
      3'b100:  bus.muxS = N'(B1);
      3'b101:  bus.muxS = N'(B2);
      default: bus.muxS = '0;
    endcase
    case (bus.controlC)
      2'b01:   bus.muxC = bus.fk1;
      2'b10:   bus.muxC = bus.fk2;
      2'b11:   bus.muxC = bus.fk;
      default: bus.muxC = '0;
    endcase
    case (bus.controlZ)
      3'b001:  bus.muxZ = bus.Uk;
      3'b010:  bus.muxZ = bus.yk;
      3'b011:  bus.muxZ = bus.acum1;
      3'b100:  bus.muxZ = bus.acum2;
      3'b101:  bus.muxZ = bus.acum3;
      default: bus.muxZ = '0;
    endcase
  end

  function automatic longint sv(input logic [N-1:0] v);
    return longint'($signed(v));
  endfunction

  // Coefficient product scaled down by 2^F, rounded toward minus infinity
  function automatic longint qmul(input longint c, input longint x);
    longint p;
    longint d;
    p = c * x;
    d = longint'(1) << F;
    if (p >= 0) return p / d;
    return -((-p + d - 1) / d);
  endfunction

  function automatic longint sat(input longint x);
    if (x > VMAX) return VMAX;
    if (x < VMIN) return VMIN;
    return x;
  endfunction

  task automatic model_clear();
    m_uk = 0; m_fk = 0; m_fk1 = 0; m_fk2 = 0;
    m_yk = 0; m_a1 = 0; m_a2 = 0; m_a3 = 0;
  endtask

  // One full filter step of the direct-form-II biquad
  task automatic model_sample(input longint uk);
    m_uk  = uk;
    m_a1  = sat(qmul(A1, m_fk1) + m_uk);
    m_fk  = sat(qmul(A2, m_fk2) + m_a1);
    m_a2  = sat(qmul(B0, m_fk));
    m_a3  = sat(qmul(B1, m_fk1) + m_a2);
    m_yk  = sat(qmul(B2, m_fk2) + m_a3);
    m_fk2 = m_fk1;
    m_fk1 = m_fk;
  endtask

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    chk({tag, "_Uk"},    sv(bus.Uk),    m_uk);
    chk({tag, "_acum1"}, sv(bus.acum1), m_a1);
    chk({tag, "_fk"},    sv(bus.fk),    m_fk);
    chk({tag, "_acum2"}, sv(bus.acum2), m_a2);
    chk({tag, "_acum3"}, sv(bus.acum3), m_a3);
    chk({tag, "_yk"},    sv(bus.yk),    m_yk);
    chk({tag, "_fk1"},   sv(bus.fk1),   m_fk1);
    chk({tag, "_fk2"},   sv(bus.fk2),   m_fk2);
  endtask

  task automatic check_idle_ctl(input string tag);
    chk({tag, "_ctlS"}, longint'(bus.controlS), 0);
    chk({tag, "_ctlC"}, longint'(bus.controlC), 0);
    chk({tag, "_ctlZ"}, longint'(bus.controlZ), 0);
    chk({tag, "_busy"}, longint'(bus.busy), 0);
    chk({tag, "_done"}, longint'(bus.done), 0);
  endtask

  // Issue one sample; imm drives start on the current negedge, glitch pulses a stray start in that cycle
  task automatic run_sample(input int uk, input bit imm, input int glitch);
    int n_done;
    int first;
    if (!imm) @(negedge clk);
    bus.start = 1'b1;
    bus.Uk_in = N'(uk);
    n_done = 0;
    first  = 0;
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      if (bus.done) begin
        n_done++;
        if (first == 0) first = cyc;
      end
      chk("busy", longint'(bus.busy), (cyc <= 6) ? 1 : 0);
      if (cyc == glitch) begin
        bus.start = 1'b1;
        bus.Uk_in = N'(1234);
      end else begin
        bus.start = 1'b0;
      end
    end
    chk("done_count", n_done, 1);
    chk("done_cycle", first, 6);
    model_sample(uk);
    check_regs("smp");
  endtask

  task automatic do_reset();
    @(negedge clk);
    bus.start = 1'b0;
    reset_n   = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    model_clear();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int uk;
    logic [N-1:0] rv;
    n_checks  = 0;
    n_fail    = 0;
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.Uk_in = '0;
    model_clear();
    repeat (2) @(negedge clk);
    check_regs("reset");
    check_idle_ctl("reset");
    reset_n = 1'b1;

    // Impulse response, first two samples
    run_sample(16384, 1'b0, 0);
    chk("imp1_acum1", sv(bus.acum1), 16384);
    chk("imp1_acum2", sv(bus.acum2), 9841);
    chk("imp1_yk",    sv(bus.yk),    9841);
    chk("imp1_fk1",   sv(bus.fk1),   16384);
    chk("imp1_fk2",   sv(bus.fk2),   0);
    run_sample(0, 1'b0, 0);
    chk("imp2_acum1", sv(bus.acum1), 16957);
    chk("imp2_fk",    sv(bus.fk),    16957);
    chk("imp2_acum2", sv(bus.acum2), 10185);
    chk("imp2_acum3", sv(bus.acum3), -9492);
    chk("imp2_yk",    sv(bus.yk),    -9492);
    chk("imp2_fk1",   sv(bus.fk1),   16957);
    chk("imp2_fk2",   sv(bus.fk2),   16384);

    // Reset in the middle of S3
    @(negedge clk);
    bus.start = 1'b1;
    bus.Uk_in = N'(16384);
    repeat (3) begin
      @(negedge clk);
      bus.start = 1'b0;
    end
    chk("s3_ctlS", longint'(bus.controlS), 3);
    chk("s3_ctlC", longint'(bus.controlC), 3);
    reset_n = 1'b0;
    #1;
    model_clear();
    check_regs("midrst");
    check_idle_ctl("midrst");
    @(negedge clk);
    reset_n = 1'b1;
    run_sample(16384, 1'b0, 0);
    chk("rerun_acum2", sv(bus.acum2), 9841);
    chk("rerun_yk",    sv(bus.yk),    9841);

    // Floor rounding of a small negative product: fk2=1, fk1=0, Uk=0
    do_reset();
    run_sample(1, 1'b0, 0);
    run_sample(-1, 1'b0, 0);
    chk("floor_pre_fk1", sv(bus.fk1), 0);
    chk("floor_pre_fk2", sv(bus.fk2), 1);
    run_sample(0, 1'b0, 0);
    chk("floor_fk", sv(bus.fk), -1);

    // Saturation at both rails
    do_reset();
    run_sample(524287, 1'b0, 0);
    run_sample(524287, 1'b0, 0);
    chk("sat_pos_acum1", sv(bus.acum1), 524287);
    do_reset();
    run_sample(-524288, 1'b0, 0);
    run_sample(-524288, 1'b0, 0);
    chk("sat_neg_acum1", sv(bus.acum1), -524288);

    // Stray start during S2, then a start right after done
    do_reset();
    run_sample(5000, 1'b0, 2);
    chk("glitch_uk", sv(bus.Uk), 5000);
    run_sample(-3000, 1'b1, 0);
    chk("b2b_uk", sv(bus.Uk), -3000);

    // Randomized samples, mixing full-range and small values
    for (int i = 0; i < 40; i++) begin
      rv = N'($urandom);
      uk = int'($signed(rv));
      if ($urandom_range(0, 2) == 0) uk = int'($urandom_range(0, 4000)) - 2000;
      run_sample(uk, 1'($urandom_range(0, 1)), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
